// File: rtl/demux1to16_regbank_wr.sv
// Write side of a 16-lane operand bank: decoded, byte-merged lane writes over valid/ready,
// plus a 16-cycle sequential bank clear. Lanes are registered and exposed flat on o_out_bus.
module demux1to16_regbank_wr #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          ZERO_LANE0 = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [3:0]            i_wr_sel,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic [WIDTH/8-1:0]    i_wr_be,
  input  logic                  i_clr_req,
  output logic                  o_clr_busy,
  output logic [16*WIDTH-1:0]   o_out_bus,
  output logic [15:0]           o_lane_valid,
  output logic [15:0]           o_wr_strobe
);

  localparam int unsigned NB = WIDTH / 8;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_lanes [16];
  logic [15:0]      r_lane_valid;
  logic [15:0]      r_strobe;
  logic             r_clr_busy;

  logic             w_wr_ready;
  logic             w_accept;
  logic             w_discard;
  logic [WIDTH-1:0] w_merged;
  logic [15:0]      w_onehot;

  // clr_req takes priority over a write presented in the same cycle
  assign w_wr_ready = (r_state == S_IDLE) && !i_clr_req && !i_rst;
  assign w_accept   = i_wr_valid && w_wr_ready;
  assign w_discard  = ZERO_LANE0 && (i_wr_sel == 4'd0);
  assign w_onehot   = 16'(1) << i_wr_sel;

  always_comb begin
    w_merged = r_lanes[i_wr_sel];
    for (int unsigned k = 0; k < NB; k++) begin
      if (i_wr_be[k]) w_merged[8*k +: 8] = i_wr_data[8*k +: 8];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_lane_valid <= '0;
      r_strobe     <= '0;
      r_clr_busy   <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) r_lanes[i] <= '0;
    end else begin
      r_strobe <= '0;
      case (r_state)
        S_IDLE: begin
          if (i_clr_req) begin
            r_state    <= S_CLEAR;
            r_clr_busy <= 1'b1;
            r_cnt      <= '0;
          end else if (w_accept && !w_discard) begin
            r_lanes[i_wr_sel]      <= w_merged;
            r_lane_valid[i_wr_sel] <= 1'b1;
            r_strobe               <= w_onehot;
          end
        end
        S_CLEAR: begin
          r_lanes[r_cnt]      <= '0;
          r_lane_valid[r_cnt] <= 1'b0;
          r_cnt               <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state    <= S_IDLE;
            r_clr_busy <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_out_bus = '0;
    for (int unsigned i = 0; i < 16; i++) o_out_bus[i*WIDTH +: WIDTH] = r_lanes[i];
  end

  assign o_wr_ready   = w_wr_ready;
  assign o_clr_busy   = r_clr_busy;
  assign o_lane_valid = r_lane_valid;
  assign o_wr_strobe  = r_strobe;

endmodule

// File: tb/tb_demux1to16_regbank_wr.sv
// Bench for demux1to16_regbank_wr: two instances (ZERO_LANE0=0 and =1) share stimulus
// and are compared every cycle against an array-based reference of the bank.
module tb_demux1to16_regbank_wr;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [3:0]  wr_sel;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        clr_req;

  logic         rdy  [2];
  logic         busy [2];
  logic [511:0] bus  [2];
  logic [15:0]  lv   [2];
  logic [15:0]  stb  [2];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // reference: lane contents per instance, and remaining clear cycles (0 = idle)
  logic [31:0] m_lane [2][16];
  logic [15:0] m_vld  [2];
  logic [15:0] m_stb  [2];
  int          m_left;

  always #5 clk = ~clk;

  demux1to16_regbank_wr #(.WIDTH(32), .ZERO_LANE0(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .o_wr_ready(rdy[0]),
    .i_wr_sel(wr_sel), .i_wr_data(wr_data), .i_wr_be(wr_be), .i_clr_req(clr_req),
    .o_clr_busy(busy[0]), .o_out_bus(bus[0]), .o_lane_valid(lv[0]), .o_wr_strobe(stb[0])
  );

  demux1to16_regbank_wr #(.WIDTH(32), .ZERO_LANE0(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .o_wr_ready(rdy[1]),
    .i_wr_sel(wr_sel), .i_wr_data(wr_data), .i_wr_be(wr_be), .i_clr_req(clr_req),
    .o_clr_busy(busy[1]), .o_out_bus(bus[1]), .o_lane_valid(lv[1]), .o_wr_strobe(stb[1])
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) m_lane[d][i] = '0;
      m_vld[d] = '0;
      m_stb[d] = '0;
    end
    m_left = 0;
  endfunction

  function automatic logic exp_ready();
    return !rst && (m_left == 0) && !clr_req;
  endfunction

  function automatic void model_step();
    for (int d = 0; d < 2; d++) begin
      m_stb[d] = '0;
      if (m_left > 0) begin
        m_lane[d][16 - m_left] = '0;
        m_vld[d][16 - m_left]  = 1'b0;
      end else if (!clr_req && wr_valid && !(d == 1 && wr_sel == 4'd0)) begin
        for (int k = 0; k < 4; k++)
          if (wr_be[k]) m_lane[d][wr_sel][8*k +: 8] = wr_data[8*k +: 8];
        m_vld[d][wr_sel] = 1'b1;
        m_stb[d][wr_sel] = 1'b1;
      end
    end
    if (m_left > 0) m_left--;
    else if (clr_req) m_left = 16;
  endfunction

  task automatic check_all(input string tag);
    logic [511:0] e;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) e[i*32 +: 32] = m_lane[d][i];
      check($sformatf("%s_bus%0d", tag, d), bus[d], e);
      check($sformatf("%s_valid%0d", tag, d), 512'(lv[d]), 512'(m_vld[d]));
      check($sformatf("%s_strobe%0d", tag, d), 512'(stb[d]), 512'(m_stb[d]));
      check($sformatf("%s_busy%0d", tag, d), 512'(busy[d]), 512'(m_left > 0));
    end
  endtask

  // called just after a falling edge; leaves the time just after the next falling edge
  task automatic cycle(input logic v, input logic [3:0] s, input logic [31:0] dat,
                       input logic [3:0] be, input logic c);
    wr_valid = v; wr_sel = s; wr_data = dat; wr_be = be; clr_req = c;
    #1;
    check("ready0", 512'(rdy[0]), 512'(exp_ready()));
    check("ready1", 512'(rdy[1]), 512'(exp_ready()));
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_sel = '0; wr_data = '0; wr_be = '0; clr_req = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // single full write then byte-masked merge
    cycle(1'b1, 4'd5, 32'hDEADBEEF, 4'hF, 1'b0);
    check("t1_lane5", 512'(bus[1][5*32 +: 32]), 512'(32'hDEADBEEF));
    check("t1_valid", 512'(lv[1]), 512'(16'h0020));
    check("t1_strobe", 512'(stb[1]), 512'(16'h0020));
    cycle(1'b1, 4'd5, 32'h11223344, 4'b0101, 1'b0);
    check("t2_lane5", 512'(bus[1][5*32 +: 32]), 512'(32'hDE22BE44));
    cycle(1'b1, 4'd1, 32'h0000_0001, 4'hF, 1'b0);
    check("t2_strobe1", 512'(stb[1]), 512'(16'h0002));
    cycle(1'b1, 4'd2, 32'h0000_0002, 4'hF, 1'b0);
    check("t2_strobe2", 512'(stb[1]), 512'(16'h0004));
    cycle(1'b1, 4'd3, 32'h0000_0003, 4'hF, 1'b0);
    check("t2_strobe3", 512'(stb[1]), 512'(16'h0008));
    cycle(1'b1, 4'd4, 32'hCAFE_F00D, 4'h0, 1'b0);

    // lane 0 write: discarded only when hardwired to zero
    cycle(1'b1, 4'd0, 32'hFFFFFFFF, 4'hF, 1'b0);
    check("t3_lane0_zero", 512'(bus[1][31:0]), 512'(32'h0));
    check("t3_strobe_zero", 512'(stb[1]), 512'(16'h0));
    check("t3_lane0_norm", 512'(bus[0][31:0]), 512'(32'hFFFFFFFF));

    // fill bank, then clear with a colliding write
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), $urandom, 4'hF, 1'b0);
    cycle(1'b1, 4'd7, 32'h12345678, 4'hF, 1'b1);
    idle(16);
    check("t4_valid_end", 512'(lv[0]), 512'(16'h0));
    check("t4_bus_end", bus[0], 512'(0));

    // reset during clear
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), $urandom, 4'hF, 1'b0);
    cycle(1'b0, 4'd0, 32'd0, 4'd0, 1'b1);
    idle(6);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("t5_async");
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 4'd9, 32'hDEADBEEF, 4'hF, 1'b0);
    check("t5_lane9", 512'(bus[1][9*32 +: 32]), 512'(32'hDEADBEEF));
    check("t5_strobe", 512'(stb[1]), 512'(16'h0200));

    // clr_req held for 20 cycles with writes pending
    for (int i = 0; i < 20; i++) cycle(1'b1, 4'(i % 16), $urandom, 4'hF, 1'b1);
    idle(16);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(0, 3) != 0), 4'($urandom), $urandom, 4'($urandom),
            ($urandom_range(0, 60) == 0));
    idle(17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
